// File: rtl/tenyr_mem_if.sv
// Core-to-memory bus: fetch port, data address/direction, enable and fault flag.
// The bidirectional data lines travel as a separate net beside this bundle.
interface tenyr_mem_if;
    logic        en;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        mem_rw;
    logic [31:0] d_addr;
    logic        halt_mem;

    modport master (
        output en,
        output i_addr,
        output mem_rw,
        output d_addr,
        input  i_data,
        input  halt_mem
    );

    modport slave (
        input  en,
        input  i_addr,
        input  mem_rw,
        input  d_addr,
        output i_data,
        output halt_mem
    );
endinterface

// File: rtl/tenyr_mem_target.sv
// Word-addressed RAM window serving instruction fetch and data accesses,
// with a sticky fault flag for data accesses that miss the window.
module tenyr_mem_target #(
  parameter logic [31:0] BASE      = 32'h00001000,
  parameter int          ADDR_BITS = 10,
  parameter string       INIT      = ""
) (
  input  logic        clk,
  input  logic        reset,
  tenyr_mem_if.slave  bus,
  inout  wire  [31:0] d_data
);
  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam logic [31:0] SPAN    = 32'(DEPTH);
  localparam logic [31:0] ILLEGAL = 32'hffffffff;

  logic [31:0]          ram [DEPTH];
  logic [31:0]          i_off;
  logic [31:0]          d_off;
  logic                 i_hit;
  logic                 d_hit;
  logic [ADDR_BITS-1:0] i_idx;
  logic [ADDR_BITS-1:0] d_idx;
  logic                 wr;
  logic                 oe;
  logic [31:0]          d_rdata;
  logic [31:0]          i_data;
  logic                 halt_mem;

  assign i_off = bus.i_addr - BASE;
  assign d_off = bus.d_addr - BASE;
  assign i_hit = i_off < SPAN;
  assign d_hit = d_off < SPAN;
  assign i_idx = i_off[ADDR_BITS-1:0];
  assign d_idx = d_off[ADDR_BITS-1:0];

  assign wr = bus.en && bus.mem_rw && d_hit;
  assign oe = bus.en && !bus.mem_rw;

  assign d_data       = oe ? d_rdata : 32'bz;
  assign bus.i_data   = i_data;
  assign bus.halt_mem = halt_mem;

  always_ff @(posedge clk) begin
    if (!reset && wr) begin
      ram[d_idx] <= d_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_data   <= ILLEGAL;
      d_rdata  <= '0;
      halt_mem <= 1'b0;
    end else if (bus.en) begin
      if (!i_hit) begin
        i_data <= ILLEGAL;
      end else if (wr && (d_idx == i_idx)) begin
        i_data <= d_data;
      end else begin
        i_data <= ram[i_idx];
      end
      if (!bus.mem_rw) begin
        d_rdata <= d_hit ? ram[d_idx] : '0;
      end
      if (!d_hit) begin
        halt_mem <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tenyr_mem_target.sv
// Directed bench for tenyr_mem_target: reset, read/write, forwarding,
// window edges, sticky fault and enable gating.
module tb_tenyr_mem_target;
    localparam logic [31:0] BASE  = 32'h00001000;
    localparam logic [31:0] DEPTH = 32'd1024;
    localparam logic [31:0] ILL   = 32'hffffffff;
    localparam logic [31:0] FLOAT = 32'hffffffff;

    logic        clk = 1'b0;
    logic        reset;
    logic        drv;
    logic [31:0] wdata;
    tri1  [31:0] d_data;
    int          n_cmp = 0;
    int          n_bad = 0;

    tenyr_mem_if bus ();

    assign d_data = drv ? wdata : 32'bz;

    tenyr_mem_target dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .d_data (d_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] v);
        bus.mem_rw = 1'b1;
        bus.d_addr = a;
        drv        = 1'b1;
        wdata      = v;
    endtask

    task automatic get(input logic [31:0] a);
        bus.mem_rw = 1'b0;
        bus.d_addr = a;
        drv        = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        bus.en     = 1'b1;
        bus.i_addr = BASE;
        drv        = 1'b0;
        wdata      = '0;
        get(BASE);
        tick();
        check("rst_i_data", bus.i_data, ILL);
        check("rst_halt", {31'b0, bus.halt_mem}, 32'd0);
        check("rst_d_rdata", d_data, 32'd0);

        reset = 1'b0;
        put(BASE, 32'h12345678);
        tick();

        // Reset with a write pending must not touch RAM[0].
        reset = 1'b1;
        put(BASE, 32'h00000055);
        tick();
        tick();
        check("rst2_i_data", bus.i_data, ILL);
        check("rst2_halt", {31'b0, bus.halt_mem}, 32'd0);

        reset      = 1'b0;
        bus.i_addr = BASE;
        get(BASE);
        tick();
        check("ram0_kept", d_data, 32'h12345678);
        check("fetch_base", bus.i_data, 32'h12345678);

        put(BASE + 3, 32'hdeadbeef);
        #1;
        check("release_on_write", d_data, 32'hdeadbeef);
        tick();
        get(BASE + 3);
        tick();
        check("readback_3", d_data, 32'hdeadbeef);

        put(BASE, 32'hcafe0001);
        bus.i_addr = BASE;
        tick();
        check("fwd_i_data", bus.i_data, 32'hcafe0001);

        get(BASE);
        bus.i_addr = BASE - 1;
        tick();
        check("miss_low", bus.i_data, ILL);
        check("read_fwd_word", d_data, 32'hcafe0001);
        check("miss_low_halt", {31'b0, bus.halt_mem}, 32'd0);

        bus.i_addr = BASE + DEPTH;
        tick();
        check("miss_high", bus.i_data, ILL);
        check("miss_high_halt", {31'b0, bus.halt_mem}, 32'd0);

        put(BASE + DEPTH - 1, 32'h00000077);
        bus.i_addr = BASE;
        tick();
        get(BASE + DEPTH - 1);
        bus.i_addr = BASE + DEPTH - 1;
        tick();
        check("last_word_d", d_data, 32'h00000077);
        check("last_word_i", bus.i_data, 32'h00000077);
        check("last_word_halt", {31'b0, bus.halt_mem}, 32'd0);

        put(BASE + DEPTH, 32'h00000001);
        tick();
        check("fault_set", {31'b0, bus.halt_mem}, 32'd1);
        get(BASE);
        tick();
        check("fault_ram0", d_data, 32'hcafe0001);
        check("fault_sticky", {31'b0, bus.halt_mem}, 32'd1);
        get(BASE - 1);
        tick();
        check("fault_rd_zero", d_data, 32'd0);
        reset = 1'b1;
        tick();
        check("fault_clear", {31'b0, bus.halt_mem}, 32'd0);
        reset = 1'b0;

        put(BASE + 5, 32'ha5a5a5a5);
        tick();
        get(BASE + 5);
        bus.i_addr = BASE + 5;
        tick();
        check("w5_d", d_data, 32'ha5a5a5a5);
        check("w5_i", bus.i_data, 32'ha5a5a5a5);

        bus.en = 1'b0;
        put(BASE + 5, 32'h5a5a5a5a);
        bus.i_addr = BASE + 3;
        tick();
        check("en0_i_hold", bus.i_data, 32'ha5a5a5a5);
        check("en0_halt", {31'b0, bus.halt_mem}, 32'd0);
        get(32'h0);
        #1;
        check("en0_float", d_data, FLOAT);
        tick();
        check("en0_oob_halt", {31'b0, bus.halt_mem}, 32'd0);
        check("en0_i_hold2", bus.i_data, 32'ha5a5a5a5);

        bus.en     = 1'b1;
        bus.i_addr = BASE + 5;
        get(BASE + 5);
        tick();
        check("en0_no_write_d", d_data, 32'ha5a5a5a5);
        check("en0_no_write_i", bus.i_data, 32'ha5a5a5a5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
